// File: rtl/ex_pkg.sv
// Shared types and constants for the execute stage and its iterative multiplier.
package ex_pkg;

  // ALU operation codes. Codes 12..15 are unused and produce a zero result.
  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_SLT   = 4'd5,
    ALU_SLTU  = 4'd6,
    ALU_SLL   = 4'd7,
    ALU_SRL   = 4'd8,
    ALU_SRA   = 4'd9,
    ALU_PASSB = 4'd10,
    ALU_MUL   = 4'd11
  } alu_op_e;

  // Operand source selection. The unused code 2'b11 behaves like FWD_REG.
  typedef enum logic [1:0] {
    FWD_REG = 2'd0,
    FWD_WB  = 2'd1,
    FWD_MEM = 2'd2
  } fwd_sel_e;

  // Conditional branch funct3 encodings. 010 and 011 are never taken.
  localparam logic [2:0] BR_EQ  = 3'b000;
  localparam logic [2:0] BR_NE  = 3'b001;
  localparam logic [2:0] BR_LT  = 3'b100;
  localparam logic [2:0] BR_GE  = 3'b101;
  localparam logic [2:0] BR_LTU = 3'b110;
  localparam logic [2:0] BR_GEU = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_e;

endpackage

// File: rtl/ex_stage_p_mul_iter.sv
// Iterative shift-add multiplier producing the low XLEN bits of a*b.
// MUL_BPC multiplier bits are retired per RUN cycle, so RUN lasts XLEN/MUL_BPC cycles.
//
// state | meaning
// IDLE  | waiting for start; operands are captured on the start edge
// RUN   | accumulating partial products, counter counts down to 0
// DONE  | product valid; held while i_hold, then back to IDLE
module mul_iter
  import ex_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int MUL_BPC = 2
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_start,
  input  logic            i_abort,
  input  logic            i_hold,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_product
);

  localparam int STEPS = XLEN / MUL_BPC;
  localparam int CW    = $clog2(STEPS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STEPS - 1);

  mul_state_e      r_state;
  mul_state_e      w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_mcand;
  logic [XLEN-1:0] r_mplier;
  logic [XLEN-1:0] r_acc;
  logic [XLEN-1:0] w_pp;

  // Partial product for the MUL_BPC low multiplier bits of this step.
  always_comb begin
    w_pp = '0;
    for (int j = 0; j < MUL_BPC; j++) begin
      if (r_mplier[j]) w_pp = w_pp + (r_mcand << j);
    end
  end

  // Next state and status outputs; abort wins over everything else.
  always_comb begin
    w_state_nxt = r_state;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start && !i_abort) w_state_nxt = RUN;
      end
      RUN: begin
        o_busy = 1'b1;
        if (i_abort)            w_state_nxt = IDLE;
        else if (r_cnt == '0)   w_state_nxt = DONE;
      end
      DONE: begin
        o_done = 1'b1;
        if (i_abort || !i_hold) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // Operand capture on start, then shift-add with down-counting step counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start && !i_abort) begin
            r_mcand  <= i_a;
            r_mplier <= i_b;
            r_acc    <= '0;
            r_cnt    <= CNT_LAST;
          end
        end
        RUN: begin
          r_acc    <= r_acc + w_pp;
          r_mcand  <= r_mcand << MUL_BPC;
          r_mplier <= r_mplier >> MUL_BPC;
          if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_product = r_acc;

endmodule

// File: rtl/ex_stage_p.sv
// Execute stage: ID/EX register with stall/flush, operand forwarding, ALU,
// branch resolution, jump target generation and an optional iterative multiplier.
// While the multiplier occupies EX the write enables and redirect are suppressed,
// so later stages see bubbles until the product is valid.
module ex_stage_p
  import ex_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int MUL_EN  = 1,
  parameter int MUL_BPC = 2
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_stall_EX,
  input  logic            i_flush_EX,
  input  logic            i_reg_write_ID,
  input  logic            i_mem_write_ID,
  input  logic [1:0]      i_result_src_ID,
  input  logic            i_jump_ID,
  input  logic            i_jalr_ID,
  input  logic            i_branch_ID,
  input  logic [2:0]      i_branch_f3_ID,
  input  logic [3:0]      i_alu_control_ID,
  input  logic            i_alu_src_ID,
  input  logic [XLEN-1:0] i_dataA_ID,
  input  logic [XLEN-1:0] i_dataB_ID,
  input  logic [XLEN-1:0] i_pc_ID,
  input  logic [XLEN-1:0] i_pc_plus4_ID,
  input  logic [XLEN-1:0] i_imm_ext_ID,
  input  logic [4:0]      i_addr_des_ID,
  input  logic [1:0]      i_fwd_a_sel,
  input  logic [1:0]      i_fwd_b_sel,
  input  logic [XLEN-1:0] i_alu_result_M,
  input  logic [XLEN-1:0] i_result_W,
  output logic            o_reg_write_EX,
  output logic            o_mem_write_EX,
  output logic [1:0]      o_result_src_EX,
  output logic [XLEN-1:0] o_alu_result_EX,
  output logic [XLEN-1:0] o_dataB_EX,
  output logic [4:0]      o_addr_des_EX,
  output logic [XLEN-1:0] o_pc_plus4_EX,
  output logic [XLEN-1:0] o_pc_target_EX,
  output logic            o_pc_src_EX,
  output logic            o_busy_EX
);

  localparam int SHW = $clog2(XLEN);

  logic            r_reg_write;
  logic            r_mem_write;
  logic [1:0]      r_result_src;
  logic            r_jump;
  logic            r_jalr;
  logic            r_branch;
  logic [2:0]      r_branch_f3;
  logic [3:0]      r_alu_control;
  logic            r_alu_src;
  logic [XLEN-1:0] r_dataA;
  logic [XLEN-1:0] r_dataB;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_pc_plus4;
  logic [XLEN-1:0] r_imm;
  logic [4:0]      r_addr_des;

  logic [XLEN-1:0] w_fwd_a;
  logic [XLEN-1:0] w_fwd_b;
  logic [XLEN-1:0] w_src_b;
  logic [SHW-1:0]  w_shamt;
  logic [XLEN-1:0] w_alu;
  logic            w_taken;
  logic [XLEN-1:0] w_jalr_sum;
  logic [XLEN-1:0] w_target;
  logic            w_is_mul;
  logic            w_mul_start;
  logic            w_mul_run;
  logic            w_mul_done;
  logic            w_mul_valid;
  logic [XLEN-1:0] w_product;
  logic            w_busy;
  logic            w_kill;

  // ID/EX register: flush beats stall/busy hold, which beats a normal load.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_reg_write   <= 1'b0;
      r_mem_write   <= 1'b0;
      r_result_src  <= '0;
      r_jump        <= 1'b0;
      r_jalr        <= 1'b0;
      r_branch      <= 1'b0;
      r_branch_f3   <= '0;
      r_alu_control <= '0;
      r_alu_src     <= 1'b0;
      r_dataA       <= '0;
      r_dataB       <= '0;
      r_pc          <= '0;
      r_pc_plus4    <= '0;
      r_imm         <= '0;
      r_addr_des    <= '0;
    end else if (i_flush_EX) begin
      r_reg_write   <= 1'b0;
      r_mem_write   <= 1'b0;
      r_result_src  <= '0;
      r_jump        <= 1'b0;
      r_jalr        <= 1'b0;
      r_branch      <= 1'b0;
      r_branch_f3   <= '0;
      r_alu_control <= '0;
      r_alu_src     <= 1'b0;
      r_dataA       <= '0;
      r_dataB       <= '0;
      r_pc          <= '0;
      r_pc_plus4    <= '0;
      r_imm         <= '0;
      r_addr_des    <= '0;
    end else if (!i_stall_EX && !w_busy) begin
      r_reg_write   <= i_reg_write_ID;
      r_mem_write   <= i_mem_write_ID;
      r_result_src  <= i_result_src_ID;
      r_jump        <= i_jump_ID;
      r_jalr        <= i_jalr_ID;
      r_branch      <= i_branch_ID;
      r_branch_f3   <= i_branch_f3_ID;
      r_alu_control <= i_alu_control_ID;
      r_alu_src     <= i_alu_src_ID;
      r_dataA       <= i_dataA_ID;
      r_dataB       <= i_dataB_ID;
      r_pc          <= i_pc_ID;
      r_pc_plus4    <= i_pc_plus4_ID;
      r_imm         <= i_imm_ext_ID;
      r_addr_des    <= i_addr_des_ID;
    end
  end

  // Operand forwarding; the unused select code falls back to the register value.
  always_comb begin
    case (i_fwd_a_sel)
      FWD_MEM: w_fwd_a = i_alu_result_M;
      FWD_WB:  w_fwd_a = i_result_W;
      default: w_fwd_a = r_dataA;
    endcase
    case (i_fwd_b_sel)
      FWD_MEM: w_fwd_b = i_alu_result_M;
      FWD_WB:  w_fwd_b = i_result_W;
      default: w_fwd_b = r_dataB;
    endcase
    w_src_b = r_alu_src ? r_imm : w_fwd_b;
  end

  assign w_shamt = w_src_b[SHW-1:0];

  // ALU; MUL degenerates to ADD when the multiplier is not built.
  always_comb begin
    w_alu = '0;
    case (r_alu_control)
      ALU_ADD:   w_alu = w_fwd_a + w_src_b;
      ALU_SUB:   w_alu = w_fwd_a - w_src_b;
      ALU_AND:   w_alu = w_fwd_a & w_src_b;
      ALU_OR:    w_alu = w_fwd_a | w_src_b;
      ALU_XOR:   w_alu = w_fwd_a ^ w_src_b;
      ALU_SLT:   w_alu = {{(XLEN-1){1'b0}}, ($signed(w_fwd_a) < $signed(w_src_b))};
      ALU_SLTU:  w_alu = {{(XLEN-1){1'b0}}, (w_fwd_a < w_src_b)};
      ALU_SLL:   w_alu = w_fwd_a << w_shamt;
      ALU_SRL:   w_alu = w_fwd_a >> w_shamt;
      ALU_SRA:   w_alu = XLEN'($signed(w_fwd_a) >>> w_shamt);
      ALU_PASSB: w_alu = w_src_b;
      ALU_MUL:   w_alu = (MUL_EN != 0) ? '0 : (w_fwd_a + w_src_b);
      default:   w_alu = '0;
    endcase
  end

  // Branch condition on the forwarded register operands.
  always_comb begin
    w_taken = 1'b0;
    case (r_branch_f3)
      BR_EQ:   w_taken = (w_fwd_a == w_fwd_b);
      BR_NE:   w_taken = (w_fwd_a != w_fwd_b);
      BR_LT:   w_taken = ($signed(w_fwd_a) < $signed(w_fwd_b));
      BR_GE:   w_taken = !($signed(w_fwd_a) < $signed(w_fwd_b));
      BR_LTU:  w_taken = (w_fwd_a < w_fwd_b);
      BR_GEU:  w_taken = !(w_fwd_a < w_fwd_b);
      default: w_taken = 1'b0;
    endcase
  end

  assign w_jalr_sum = w_fwd_a + r_imm;
  assign w_target   = r_jalr ? {w_jalr_sum[XLEN-1:1], 1'b0} : (r_pc + r_imm);

  // Multiplier starts only from IDLE, and a flush in that cycle cancels it.
  assign w_is_mul    = (MUL_EN != 0) && (r_alu_control == ALU_MUL);
  assign w_mul_start = w_is_mul && !w_mul_run && !w_mul_done && !i_flush_EX;

  generate
    if (MUL_EN != 0) begin : g_mul
      mul_iter #(
        .XLEN    (XLEN),
        .MUL_BPC (MUL_BPC)
      ) u_mul (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_start   (w_mul_start),
        .i_abort   (i_flush_EX),
        .i_hold    (i_stall_EX),
        .i_a       (w_fwd_a),
        .i_b       (w_src_b),
        .o_busy    (w_mul_run),
        .o_done    (w_mul_done),
        .o_product (w_product)
      );
    end else begin : g_no_mul
      assign w_mul_run  = 1'b0;
      assign w_mul_done = 1'b0;
      assign w_product  = '0;
    end
  endgenerate

  // A MUL only produces side effects in DONE; an aborted one never does.
  assign w_busy      = w_mul_start || w_mul_run;
  assign w_mul_valid = w_mul_done && !i_flush_EX;
  assign w_kill      = w_busy || (w_is_mul && !w_mul_valid);

  assign o_reg_write_EX  = r_reg_write && !w_kill;
  assign o_mem_write_EX  = r_mem_write && !w_kill;
  assign o_pc_src_EX     = (r_jump || (r_branch && w_taken)) && !w_kill;
  assign o_result_src_EX = r_result_src;
  assign o_alu_result_EX = w_is_mul ? w_product : w_alu;
  assign o_dataB_EX      = w_fwd_b;
  assign o_addr_des_EX   = r_addr_des;
  assign o_pc_plus4_EX   = r_pc_plus4;
  assign o_pc_target_EX  = w_target;
  assign o_busy_EX       = w_busy;

endmodule
